dest_reg_scoreboard: RTL and testbench
======================================

Name: dest_reg_scoreboard

Overview:
Tracks destination registers that are in flight in the pipeline, from issue to writeback.
- Issue side: consumes the 5-bit destination chosen by the rt/rd destination select mux and marks that register pending.
- Writeback side: clears the pending mark when the result retires.
- Decode side: compares its rs/rt against the pending set and raises stall on a read-after-write hazard.
- Sits between ID/EX (issue) and MEM/WB (retire), alongside the hazard logic.

Parameters:
CNT_W, 2, width of each per-register in-flight counter; max outstanding writes per register = 2^CNT_W - 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
issue_valid  input  1  a destination write is being issued this cycle.
issue_reg  input  5  destination register number from the destination select mux.
issue_ready  output  1  the scoreboard can accept the issue on issue_reg this cycle.
wb_valid  input  1  a register write is retiring this cycle.
wb_reg  input  5  register number being written back.
rs  input  5  decode-stage source register 1.
rt  input  5  decode-stage source register 2.
stall  output  1  rs or rt has an outstanding write.
busy_vec  output  32  bit i = 1 when counter i is non-zero.
inflight  output  CNT_W+5  total outstanding writes across all registers.
wb_underflow  output  1  sticky error: a writeback arrived for a register with no outstanding write.

Behaviour:
- State: 32 counters cnt[i] of CNT_W bits, an inflight accumulator, and a sticky wb_underflow bit.
- Reset (async, active-high, takes effect immediately):
  - all cnt = 0, inflight = 0, wb_underflow = 0;
  - therefore busy_vec = 0, stall = 0, issue_ready = 1.
- Register 0:
  - never pending; issues and writebacks to register 0 are ignored;
  - issue_ready = 1 whenever issue_reg = 0;
  - rs = 0 or rt = 0 never causes a stall.
- Combinational outputs:
  - issue_ready = (issue_reg == 0) or (cnt[issue_reg] != 2^CNT_W - 1);
  - stall = (rs != 0 and cnt[rs] != 0) or (rt != 0 and cnt[rt] != 0);
  - stall uses registered state only; a same-cycle writeback does not bypass it, so stall releases the cycle after writeback.
  - busy_vec[i] = (cnt[i] != 0); busy_vec[0] = 0.
- Issue accept condition: issue_valid & issue_ready & issue_reg != 0.
  - When accepted: cnt[issue_reg] += 1 at the next edge.
  - When issue_valid and not issue_ready: nothing changes; upstream holds issue_valid/issue_reg.
- Writeback accept condition: wb_valid & wb_reg != 0 & cnt[wb_reg] != 0.
  - When accepted: cnt[wb_reg] -= 1 at the next edge.
  - When wb_valid, wb_reg != 0 and cnt[wb_reg] == 0: counter stays 0 and wb_underflow is set to 1, held until reset.
- Simultaneous issue and writeback:
  - Different registers: both apply.
  - Same register: net counter change is 0 provided both are accepted.
  - Issue-readiness is evaluated on the pre-edge count, so at max count the issue is refused even if the same-cycle writeback would free a slot.
- inflight tracks accepted operations: +1 per accepted issue, -1 per accepted writeback, net 0 when both occur.
  - Invariant: inflight = sum of all cnt[i].
  - Counters never wrap.
- Latency: issue or writeback to visible busy_vec/stall change is 1 cycle.

Test Plan:
1. Assert reset mid-run with cnt[5]=2, inflight=2 -> outputs cleared immediately (asynchronously, not at the next edge): busy_vec=0, inflight=0, stall=0, wb_underflow=0.
2. Issue reg 8 for one cycle; next cycle rs=8 -> busy_vec=0x00000100, stall=1, inflight=1. Then wb_reg=8 -> stall still 1 that cycle; 0 the following cycle; inflight=0.
3. Issue reg 3 three times back-to-back (CNT_W=2) -> cnt[3]=3, issue_ready=0 when issue_reg=3. A fourth issue held 2 cycles is ignored, inflight stays 3. One writeback to 3 -> issue_ready=1 next cycle.
4. issue_reg=12 and wb_reg=12 same cycle with cnt[12]=1 -> cnt[12] stays 1, inflight unchanged. issue_reg=4, wb_reg=12 same cycle -> cnt[4]=1, cnt[12]=0, inflight unchanged.
5. Issue reg 0 five times; rs=0, rt=0 -> busy_vec=0, stall=0, inflight=0, issue_ready=1 throughout.
6. Writeback reg 20 with cnt[20]=0 -> wb_underflow=1 next cycle and held; cnt[20]=0, inflight unchanged; later a normal issue/writeback of 20 works and wb_underflow stays 1 until reset.

Source files
------------

// File: rtl/dest_reg_scoreboard.sv
// rtl/dest_reg_scoreboard.sv - per-register in-flight write counters with RAW stall detection
module dest_reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic [4:0]         issue_reg,
    output logic               issue_ready,
    input  logic               wb_valid,
    input  logic [4:0]         wb_reg,
    input  logic [4:0]         rs,
    input  logic [4:0]         rt,
    output logic               stall,
    output logic [31:0]        busy_vec,
    output logic [CNT_W+4:0]   inflight,
    output logic               wb_underflow
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W+4:0] INF_ONE = (CNT_W+5)'(1);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [CNT_W+4:0] inflight_q, inflight_d;
    logic             wb_underflow_q, wb_underflow_d;

    logic issue_acc, wb_hit, wb_acc;

    assign issue_ready  = (issue_reg == 5'd0) || (cnt_q[issue_reg] != CNT_MAX);
    assign inflight     = inflight_q;
    assign wb_underflow = wb_underflow_q;

    // Stall looks only at registered counts: a same-cycle writeback is not bypassed.
    assign stall = ((rs != 5'd0) && (cnt_q[rs] != '0)) ||
                   ((rt != 5'd0) && (cnt_q[rt] != '0));

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < 32; i++) begin
            busy_vec[i] = (cnt_q[i] != '0);
        end
    end

    always_comb begin
        issue_acc = issue_valid && issue_ready && (issue_reg != 5'd0);
        wb_hit    = wb_valid && (wb_reg != 5'd0);
        wb_acc    = wb_hit && (cnt_q[wb_reg] != '0);

        cnt_d = cnt_q;
        for (int i = 1; i < 32; i++) begin
            if (issue_acc && (issue_reg == i[4:0]) && !(wb_acc && (wb_reg == i[4:0]))) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (wb_acc && (wb_reg == i[4:0]) && !(issue_acc && (issue_reg == i[4:0]))) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end

        inflight_d = inflight_q;
        case ({issue_acc, wb_acc})
            2'b10:   inflight_d = inflight_q + INF_ONE;
            2'b01:   inflight_d = inflight_q - INF_ONE;
            default: inflight_d = inflight_q;
        endcase

        wb_underflow_d = wb_underflow_q || (wb_hit && (cnt_q[wb_reg] == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            inflight_q     <= '0;
            wb_underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            inflight_q     <= inflight_d;
            wb_underflow_q <= wb_underflow_d;
        end
    end
endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// tb/tb_dest_reg_scoreboard.sv - self-checking bench for dest_reg_scoreboard
module tb_dest_reg_scoreboard;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid;
    logic [4:0]       issue_reg;
    logic             issue_ready;
    logic             wb_valid;
    logic [4:0]       wb_reg;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             stall;
    logic [31:0]      busy_vec;
    logic [CNT_W+4:0] inflight;
    logic             wb_underflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dest_reg_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_reg(wb_reg),
        .rs(rs), .rt(rt), .stall(stall),
        .busy_vec(busy_vec), .inflight(inflight), .wb_underflow(wb_underflow)
    );

    always #5 clk = ~clk;

    // Model: one integer count per register plus the sticky error flag.
    int  mcnt [32] = '{default: 0};
    bit  munder = 1'b0;
    logic m_ia, m_wa, m_uf;
    assign m_ia = issue_valid && (issue_reg != 0) && (mcnt[issue_reg] < MAXC);
    assign m_wa = wb_valid && (wb_reg != 0) && (mcnt[wb_reg] > 0);
    assign m_uf = wb_valid && (wb_reg != 0) && (mcnt[wb_reg] == 0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mcnt[i] <= 0;
            munder <= 1'b0;
        end else begin
            if (!(m_ia && m_wa && issue_reg == wb_reg)) begin
                if (m_ia) mcnt[issue_reg] <= mcnt[issue_reg] + 1;
                if (m_wa) mcnt[wb_reg] <= mcnt[wb_reg] - 1;
            end
            if (m_uf) munder <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        logic [31:0] e_busy;
        int          e_sum;
        e_busy = '0;
        e_sum  = 0;
        for (int i = 1; i < 32; i++) begin
            e_busy[i] = (mcnt[i] != 0);
            e_sum += mcnt[i];
        end
        check("cmp_busy_vec", 64'(busy_vec), 64'(e_busy));
        check("cmp_inflight", 64'(inflight), 64'(e_sum));
        check("cmp_underflow", 64'(wb_underflow), 64'(munder));
        check("cmp_issue_ready", 64'(issue_ready),
              64'((issue_reg == 0) || (mcnt[issue_reg] != MAXC)));
        check("cmp_stall", 64'(stall),
              64'(((rs != 0) && (mcnt[rs] != 0)) || ((rt != 0) && (mcnt[rt] != 0))));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; issue_valid = 0; issue_reg = 0; wb_valid = 0; wb_reg = 0; rs = 0; rt = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        at_neg();
        check("rst_busy", 64'(busy_vec), 64'h0);
        check("rst_inflight", 64'(inflight), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        check("rst_ready", 64'(issue_ready), 64'h1);
        check("rst_under", 64'(wb_underflow), 64'h0);

        // Single issue, stall held through the writeback cycle.
        step(); issue_valid = 1; issue_reg = 8;
        step(); issue_valid = 0; rs = 8;
        at_neg();
        check("t2_busy", 64'(busy_vec), 64'h100);
        check("t2_stall", 64'(stall), 64'h1);
        check("t2_inflight", 64'(inflight), 64'h1);
        step(); wb_valid = 1; wb_reg = 8;
        at_neg();
        check("t2_stall_wb_cycle", 64'(stall), 64'h1);
        step(); wb_valid = 0;
        at_neg();
        check("t2_stall_released", 64'(stall), 64'h0);
        check("t2_inflight0", 64'(inflight), 64'h0);
        rs = 0;

        // Saturate register 3, hold a refused fourth issue.
        step(); issue_valid = 1; issue_reg = 3;
        step(); step(); step();
        at_neg();
        check("t3_ready_full", 64'(issue_ready), 64'h0);
        check("t3_inflight3", 64'(inflight), 64'h3);
        step(); step();
        at_neg();
        check("t3_held_inflight", 64'(inflight), 64'h3);
        check("t3_held_ready", 64'(issue_ready), 64'h0);
        issue_valid = 0; wb_valid = 1; wb_reg = 3;
        step(); wb_valid = 0;
        at_neg();
        check("t3_ready_again", 64'(issue_ready), 64'h1);
        check("t3_inflight2", 64'(inflight), 64'h2);
        wb_valid = 1; wb_reg = 3;
        step(); step(); wb_valid = 0;

        // Simultaneous issue/writeback, same and different registers.
        issue_valid = 1; issue_reg = 12;
        step(); wb_valid = 1; wb_reg = 12;
        step(); issue_valid = 0; wb_valid = 0;
        at_neg();
        check("t4_same_busy", 64'(busy_vec), 64'h1000);
        check("t4_same_inflight", 64'(inflight), 64'h1);
        issue_valid = 1; issue_reg = 4; wb_valid = 1; wb_reg = 12;
        step(); issue_valid = 0; wb_valid = 0;
        at_neg();
        check("t4_diff_busy", 64'(busy_vec), 64'h10);
        check("t4_diff_inflight", 64'(inflight), 64'h1);
        wb_valid = 1; wb_reg = 4;
        step(); wb_valid = 0;

        // Register 0 is never tracked.
        issue_valid = 1; issue_reg = 0; rs = 0; rt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            at_neg();
            check("t5_busy", 64'(busy_vec), 64'h0);
            check("t5_stall", 64'(stall), 64'h0);
            check("t5_ready", 64'(issue_ready), 64'h1);
            check("t5_inflight", 64'(inflight), 64'h0);
        end
        issue_valid = 0;

        // Underflow is sticky across later normal traffic.
        step(); wb_valid = 1; wb_reg = 20;
        step(); wb_valid = 0;
        at_neg();
        check("t6_under_set", 64'(wb_underflow), 64'h1);
        check("t6_inflight", 64'(inflight), 64'h0);
        check("t6_busy", 64'(busy_vec), 64'h0);
        issue_valid = 1; issue_reg = 20;
        step(); issue_valid = 0; rt = 20;
        at_neg();
        check("t6_stall", 64'(stall), 64'h1);
        check("t6_busy20", 64'(busy_vec), 64'h100000);
        check("t6_under_held", 64'(wb_underflow), 64'h1);
        wb_valid = 1; wb_reg = 20;
        step(); wb_valid = 0;
        at_neg();
        check("t6_stall_clear", 64'(stall), 64'h0);
        check("t6_under_still", 64'(wb_underflow), 64'h1);
        check("t6_inflight0", 64'(inflight), 64'h0);
        rt = 0;

        // Mid-cycle asynchronous reset with outstanding writes.
        issue_valid = 1; issue_reg = 5;
        step(); step(); issue_valid = 0; rs = 5;
        at_neg();
        check("t1_inflight2", 64'(inflight), 64'h2);
        check("t1_stall_pre", 64'(stall), 64'h1);
        #2 reset = 1'b1;
        #1;
        check("t1_busy", 64'(busy_vec), 64'h0);
        check("t1_inflight", 64'(inflight), 64'h0);
        check("t1_stall", 64'(stall), 64'h0);
        check("t1_under", 64'(wb_underflow), 64'h0);
        step(); reset = 1'b0; rs = 0;
        step();
        at_neg();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
